// File: rtl/digit_text_render.sv
// Renders NUM_DIGITS BCD digits as 8x16 glyphs from an external registered font ROM; 2-clock fixed latency, no stalls.
// Optional LEADING_ZERO_BLANK_EN: blank zero digits left of the first non-zero digit (LS digit always drawn).
module digit_text_render #(
  parameter int X0         = 0,
  parameter int Y0         = 0,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    video_on,
  input  logic [9:0]              pixel_x,
  input  logic [9:0]              pixel_y,
  input  logic                    frame_start,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [10:0]             rom_addr,
  input  logic [7:0]              rom_data,
  output logic                    pixel_out,
  output logic                    text_on,
  output logic                    update_pending
);

  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0]  shadow;
  logic [W-1:0]  active;
  logic [11:0]   dx;
  logic [11:0]   dy;
  logic          in_field;
  logic [2:0]    idx;
  logic [2:0]    col;
  logic [3:0]    row;
  logic [3:0]    dig [8];
  logic [7:0]    blank;
  logic [3:0]    cur_digit;
  logic [6:0]    char_code;
  logic          in_s1;
  logic [2:0]    col_s1;

  // 12-bit differences: bit 11 set means the pixel is above/left of the field (no wraparound).
  assign dx = {2'b00, pixel_x} - 12'(X0);
  assign dy = {2'b00, pixel_y} - 12'(Y0);

  assign in_field = video_on
                  && !dx[11] && (dx[10:0] < 11'(8 * NUM_DIGITS))
                  && !dy[11] && (dy[10:0] < 11'd16);

  assign idx = dx[5:3];
  assign col = dx[2:0];
  assign row = dy[3:0];

  always_comb begin
    for (int i = 0; i < 8; i++) dig[i] = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) dig[i] = active[W-4-4*i +: 4];
  end

  always_comb begin
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig[i] != 4'd0) seen = 1'b1;
        blank[i] = !seen && (i != NUM_DIGITS - 1);
      end
    end
`endif
  end

  assign cur_digit = dig[idx];

  always_comb begin
    char_code = 7'h7f;
    if (blank[idx])
      char_code = 7'h00;
    else if (cur_digit <= 4'd9)
      char_code = 7'h30 + {3'b000, cur_digit};
  end

  assign rom_addr = in_field ? {char_code, row} : 11'h000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow         <= '0;
      active         <= '0;
      update_pending <= 1'b0;
    end else if (load && frame_start) begin
      shadow         <= digits_in;
      active         <= digits_in;
      update_pending <= 1'b0;
    end else if (frame_start) begin
      active         <= shadow;
      update_pending <= 1'b0;
    end else if (load) begin
      shadow         <= digits_in;
      update_pending <= 1'b1;
    end
  end

  // Stage 1 runs alongside the ROM's own address register; stage 2 picks the glyph bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_s1     <= 1'b0;
      col_s1    <= 3'd0;
      pixel_out <= 1'b0;
      text_on   <= 1'b0;
    end else begin
      in_s1     <= in_field;
      col_s1    <= col;
      pixel_out <= in_s1 & rom_data[3'd7 - col_s1];
      text_on   <= in_s1;
    end
  end

endmodule

// File: tb/tb_digit_text_render.sv
// Directed bench for digit_text_render with a behavioural registered font ROM.
module tb_digit_text_render;

  localparam int X0 = 16;
  localparam int Y0 = 8;
  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        video_on = 1'b1;
  logic [9:0]  pixel_x = 10'd0;
  logic [9:0]  pixel_y = 10'd0;
  logic        frame_start = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        pixel_out;
  logic        text_on;
  logic        update_pending;

  int tests = 0;
  int fails = 0;

  digit_text_render #(.X0(X0), .Y0(Y0), .NUM_DIGITS(ND)) dut (
    .clk(clk), .reset(reset), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
    .load(load), .digits_in(digits_in), .rom_addr(rom_addr),
    .rom_data(rom_data), .pixel_out(pixel_out), .text_on(text_on),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  // Font: blank=00, block=FF, '1'=vertical bar 18, other digits {low nibble of code, row}.
  function automatic logic [7:0] font(input logic [10:0] a);
    logic [6:0] c;
    logic [3:0] r;
    c = a[10:4];
    r = a[3:0];
    if (c == 7'h00) return 8'h00;
    if (c == 7'h7f) return 8'hff;
    if (c == 7'h31) return 8'h18;
    return {c[3:0], r};
  endfunction

  always @(posedge clk) rom_data <= font(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_pix(input int x, input int y);
    @(negedge clk);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    set_pix(x, y);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic fs);
    @(negedge clk);
    load = 1'b1;
    frame_start = fs;
    digits_in = d;
    @(negedge clk);
    load = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic do_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    pixel_x = 10'(X0);
    pixel_y = 10'(Y0);
    #3;
    check("reset_pixel_out", pixel_out, 0);
    check("reset_text_on", text_on, 0);
    check("reset_pending", update_pending, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_text_on", text_on, 0);
    @(negedge clk);
    reset = 1'b0;

    do_load(16'h1234, 1'b0);
    check("load_pending", update_pending, 1);
    do_frame();
    check("frame_pending", update_pending, 0);

    pat = 8'h18;
    for (int c = 0; c < 8; c++) begin
      pix(X0 + c, Y0 + 2);
      check($sformatf("row2_col%0d", c), pixel_out, pat[7-c]);
      check($sformatf("row2_on%0d", c), text_on, 1);
    end
    set_pix(X0 + 3, Y0 + 2);
    check("addr_1_row2", rom_addr, 11'h312);
    set_pix(X0 + 8, Y0 + 2);
    check("addr_2_row2", rom_addr, 11'h322);
    set_pix(X0 + 31, Y0 + 15);
    check("addr_4_row15", rom_addr, 11'h34f);

    set_pix(X0 - 1, Y0);
    check("left_under_addr", rom_addr, 11'h000);
    pix(X0 - 1, Y0);
    check("left_under_on", text_on, 0);
    set_pix(X0, Y0 - 1);
    check("top_under_addr", rom_addr, 11'h000);
    set_pix(X0 + 32, Y0);
    check("right_edge_addr", rom_addr, 11'h000);
    set_pix(X0, Y0 + 16);
    check("bottom_edge_addr", rom_addr, 11'h000);
    @(negedge clk);
    video_on = 1'b0;
    pix(X0, Y0);
    check("video_off_on", text_on, 0);
    check("video_off_addr", rom_addr, 11'h000);
    video_on = 1'b1;

    do_load(16'h0007, 1'b0);
    check("midframe_pending", update_pending, 1);
    set_pix(X0, Y0 + 2);
    check("midframe_unchanged", rom_addr, 11'h312);
    do_frame();
    check("after_frame_pending", update_pending, 0);
    set_pix(X0, Y0 + 2);
`ifdef LEADING_ZERO_BLANK_EN
    check("cell0_0007", rom_addr, 11'h002);
    set_pix(X0 + 16, Y0 + 2);
    check("cell2_0007", rom_addr, 11'h002);
`else
    check("cell0_0007", rom_addr, 11'h302);
    set_pix(X0 + 16, Y0 + 2);
    check("cell2_0007", rom_addr, 11'h302);
`endif
    set_pix(X0 + 24, Y0 + 2);
    check("cell3_0007", rom_addr, 11'h372);
    pix(X0 + 24, Y0 + 2);
    check("seven_col0", pixel_out, 0);
    pix(X0 + 25, Y0 + 2);
    check("seven_col1", pixel_out, 1);

    do_load(16'h5555, 1'b0);
    do_load(16'h9999, 1'b1);
    check("same_cycle_pending", update_pending, 0);
    set_pix(X0, Y0 + 5);
    check("same_cycle_cell0", rom_addr, 11'h395);
    set_pix(X0 + 24, Y0 + 5);
    check("same_cycle_cell3", rom_addr, 11'h395);

    do_load(16'hA000, 1'b1);
    set_pix(X0, Y0);
    check("digitA_addr", rom_addr, 11'h7f0);
    for (int c = 0; c < 8; c++) begin
      pix(X0 + c, Y0);
      check($sformatf("digitA_col%0d", c), pixel_out, 1);
    end
    set_pix(X0 + 24, Y0);
    check("zero_after_A", rom_addr, 11'h300);

    pix(X0, Y0);
    set_pix(X0 - 1, Y0);
    @(posedge clk);
    #1;
    check("latency_hold_on", text_on, 1);
    @(posedge clk);
    #1;
    check("latency_drop_on", text_on, 0);

    pix(X0 + 2, Y0 + 3);
    check("pre_reset_on", text_on, 1);
    check("pre_reset_px", pixel_out, 1);
    do_load(16'h4321, 1'b0);
    check("pre_reset_pending", update_pending, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_px", pixel_out, 0);
    check("async_on", text_on, 0);
    check("async_pending", update_pending, 0);
    @(negedge clk);
    reset = 1'b0;
    set_pix(X0, Y0 + 4);
`ifdef LEADING_ZERO_BLANK_EN
    check("post_reset_cell0", rom_addr, 11'h004);
`else
    check("post_reset_cell0", rom_addr, 11'h304);
`endif
    set_pix(X0 + 24, Y0 + 4);
    check("post_reset_cell3", rom_addr, 11'h304);
    check("post_reset_pending", update_pending, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/digit_text_render.md
DIGIT_TEXT_RENDER -- requirements
Module: digit_text_render

Interface
REQ-001 Parameter X0, default 0, left pixel column of the text field.
REQ-002 Parameter Y0, default 0, top pixel row of the text field.
REQ-003 Parameter NUM_DIGITS, default 4, digit count, legal range 1..8.
REQ-004 clk  input  1  single pixel clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 video_on  input  1  visible-area flag from sync generator.
REQ-007 pixel_x  input  10  current pixel column.
REQ-008 pixel_y  input  10  current pixel row.
REQ-009 frame_start  input  1  one-cycle strobe at first pixel of each frame.
REQ-010 load  input  1  one-cycle strobe; capture digits_in.
REQ-011 digits_in  input  4*NUM_DIGITS  BCD digits, MS digit in top nibble.
REQ-012 rom_addr  output  11  font ROM address {char_code[6:0], row[3:0]}; combinational.
REQ-013 rom_data  input  8  font row from ROM, valid one cycle after rom_addr (ROM registers its address).
REQ-014 pixel_out  output  1  registered glyph pixel.
REQ-015 text_on  output  1  registered, high when pixel lies inside text field.
REQ-016 update_pending  output  1  shadow holds digits not yet displayed.

Function
REQ-017 Field = X0 <= pixel_x < X0+8*NUM_DIGITS and Y0 <= pixel_y < Y0+16, qualified by video_on.
REQ-018 Digit index = (pixel_x-X0)>>3, index 0 = leftmost = most significant nibble; column = (pixel_x-X0)[2:0]; row = (pixel_y-Y0)[3:0].
REQ-019 char_code = 7'h30 + digit for digit 0..9; digit 10..15 maps to 7'h7f (solid block).
REQ-020 Outside field, rom_addr = 11'h000 (null glyph).
REQ-021 Stage 1 register: in-field flag, column; captured each cycle alongside rom_addr presentation.
REQ-022 Stage 2 register: pixel_out = in-field_s1 AND rom_data[7 - column_s1]; text_on = in-field_s1.
REQ-023 Latency pixel_x/pixel_y -> pixel_out/text_on = 2 clocks, fixed, no stalls.
REQ-024 load: shadow <= digits_in, update_pending <= 1.
REQ-025 frame_start: active <= shadow, update_pending <= 0; glyph lookup uses active only (no mid-frame tearing).
REQ-026 load and frame_start same cycle: active <= digits_in, shadow <= digits_in, update_pending <= 0.
REQ-027 Subtraction underflow (pixel_x < X0 or pixel_y < Y0) SHALL be treated as outside field, never as wrapped index.

Reset
REQ-028 On reset assertion, immediately: shadow = 0, active = 0, update_pending = 0, stage-1/stage-2 registers = 0, pixel_out = 0, text_on = 0.
REQ-029 Reset mid-frame discards pending load; display shows "0...0" (or blanks per REQ-031) from the next cycle after deassertion.

Configuration
REQ-030 Macro LEADING_ZERO_BLANK_EN compiled out: every zero digit renders as glyph 0x30.
REQ-031 Macro LEADING_ZERO_BLANK_EN defined: zero digits left of the first non-zero digit render as char_code 7'h00 (blank); least significant digit always rendered; digits >9 count as non-zero.

Verification
REQ-032 Reset, load 16'h1234, frame_start, scan row Y0+2: column X0..X0+7 pixel_out pattern 00011000 two clocks after each pixel.
REQ-033 load 16'h0007 without LEADING_ZERO_BLANK_EN -> glyphs "0007"; with macro -> three blank cells, rom_addr 11'h002 at row 2 of cell 0, then "7".
REQ-034 load mid-frame, no frame_start -> display unchanged, update_pending = 1; after frame_start -> new digits shown, update_pending = 0.
REQ-035 load and frame_start same cycle with 16'h9999 -> next frame shows "9999", update_pending = 0.
REQ-036 Digit 4'hA at row 0 -> rom_addr 11'h7f0, pixel_out = 1 across all 8 columns; pixel_x = X0-1 -> text_on = 0, rom_addr 11'h000.
REQ-037 reset asserted while text_on = 1 -> pixel_out and text_on drop to 0 without waiting for a clock edge.
